rr_bus_arbiter: RTL

- Round-robin arbiter that shares one WIDTH-bit result bus between four requesters.
- Drives the 2-bit select of an internal mux4to1 so that exactly one source at a time reaches the downstream consumer.
- Sits in front of the shared write-back/result path of the pipeline datapath.
- Supports multi-beat ownership, capped by MAX_HOLD, and downstream backpressure.

---
 rtl/rr_arb_pkg.sv | 21 ++
 rtl/rr_bus_arbiter_mux4to1.sv | 26 ++
 rtl/rr_bus_arbiter.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/rr_arb_pkg.sv
// Shared definitions for the round-robin result-bus arbiter.
//   NUM_REQ     : number of requesters sharing the bus
//   SEL_W       : width of the mux select / owner index
//   arb_state_e : arbiter FSM encoding (IDLE, OWN)
//   onehot()    : converts an owner index into a one-hot grant vector
package rr_arb_pkg;

   localparam int NUM_REQ = 4;
   localparam int SEL_W   = 2;

   typedef enum logic {
      IDLE = 1'b0,
      OWN  = 1'b1
   } arb_state_e;

   function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] sel);
      onehot      = '0;
      onehot[sel] = 1'b1;
   endfunction

endpackage

// File: rtl/rr_bus_arbiter_mux4to1.sv
// Four-input, WIDTH-bit combinational multiplexer feeding the shared result bus.
// Ports:
//   sel        : 2-bit source select
//   d0..d3     : source data
//   y          : selected data
module mux4to1 #(
   parameter int WIDTH = 16
) (
   input  logic [1:0]       sel,
   input  logic [WIDTH-1:0] d0,
   input  logic [WIDTH-1:0] d1,
   input  logic [WIDTH-1:0] d2,
   input  logic [WIDTH-1:0] d3,
   output logic [WIDTH-1:0] y
);

   always_comb begin
      case (sel)
         2'd0:    y = d0;
         2'd1:    y = d1;
         2'd2:    y = d2;
         default: y = d3;
      endcase
   end

endmodule

// File: rtl/rr_bus_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit result bus between four requesters.
// An owner keeps the bus for up to MAX_HOLD accepted beats, or until it drops
// its request; the next owner is chosen in the same cycle so grants chain
// back-to-back without an idle bubble. Downstream backpressure freezes the
// burst in place.
// Optional build macro: RR_ARB_PRIO0_EN -- requester 0 wins every arbitration
// point it requests at, without moving the rotation pointer.
// Ports:
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   req[3:0]   : per-requester beat-valid
//   d0..d3     : per-requester data
//   out_ready  : downstream accepts the current beat
//   gnt[3:0]   : registered one-hot grant (zero when idle)
//   sel[1:0]   : registered mux select (owner index)
//   y          : selected data
//   y_valid    : beat on y is valid
module rr_bus_arbiter
   import rr_arb_pkg::*;
#(
   parameter int WIDTH    = 16,
   parameter int MAX_HOLD = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req,
   input  logic [WIDTH-1:0]   d0,
   input  logic [WIDTH-1:0]   d1,
   input  logic [WIDTH-1:0]   d2,
   input  logic [WIDTH-1:0]   d3,
   input  logic               out_ready,
   output logic [NUM_REQ-1:0] gnt,
   output logic [SEL_W-1:0]   sel,
   output logic [WIDTH-1:0]   y,
   output logic               y_valid
);

   localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

   arb_state_e         state_q, state_d;
   logic [NUM_REQ-1:0] gnt_q,   gnt_d;
   logic [SEL_W-1:0]   sel_q,   sel_d;
   logic [SEL_W-1:0]   ptr_q,   ptr_d;
   logic [3:0]         cnt_q,   cnt_d;

   logic               accept;
   logic               release_own;
   logic [SEL_W-1:0]   ptr_rel;
   logic [SEL_W-1:0]   win_idle;
   logic [SEL_W-1:0]   win_rel;

   // First requester at or after 'start' in circular order.
   function automatic logic [SEL_W-1:0] pick(input logic [NUM_REQ-1:0] r,
                                             input logic [SEL_W-1:0]   start);
      logic [SEL_W-1:0] idx;
      logic             found;
      pick  = start;
      found = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = start + SEL_W'(k);
         if (!found && r[idx]) begin
            pick  = idx;
            found = 1'b1;
         end
      end
`ifdef RR_ARB_PRIO0_EN
      if (r[0]) pick = '0;
`endif
   endfunction

   always_comb begin
      y_valid     = (state_q == OWN) && req[sel_q];
      accept      = y_valid && out_ready;
      release_own = (state_q == OWN) &&
                    (!req[sel_q] || (accept && (cnt_q == HOLD_LAST)));
`ifdef RR_ARB_PRIO0_EN
      // A requester-0 tenure never advances the rotation among 1..3.
      ptr_rel     = (sel_q == '0) ? ptr_q : sel_q + 2'd1;
`else
      ptr_rel     = sel_q + 2'd1;
`endif
      win_idle    = pick(req, ptr_q);
      win_rel     = pick(req, ptr_rel);

      state_d = state_q;
      gnt_d   = gnt_q;
      sel_d   = sel_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;

      case (state_q)
         IDLE: begin
            if (|req) begin
               state_d = OWN;
               sel_d   = win_idle;
               gnt_d   = onehot(win_idle);
               cnt_d   = '0;
            end
         end
         default: begin
            if (release_own) begin
               ptr_d = ptr_rel;
               cnt_d = '0;
               if (|req) begin
                  sel_d = win_rel;
                  gnt_d = onehot(win_rel);
               end else begin
                  state_d = IDLE;
                  gnt_d   = '0;
                  sel_d   = '0;
               end
            end else if (accept) begin
               cnt_d = cnt_q + 4'd1;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         sel_q   <= '0;
         ptr_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         sel_q   <= sel_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
      end
   end

   assign gnt = gnt_q;
   assign sel = sel_q;

   mux4to1 #(.WIDTH(WIDTH)) u_mux (
      .sel (sel_q),
      .d0  (d0),
      .d1  (d1),
      .d2  (d2),
      .d3  (d3),
      .y   (y)
   );

endmodule
